write_ptr_ctrl: RTL and testbench



---
 rtl/write_ptr_ctrl.sv | 83 ++++++++
 tb/tb_write_ptr_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/write_ptr_ctrl.sv
// Write-side pointer and status controller for an asynchronous FIFO.
// Keeps the binary/Gray write pointer, decodes the synchronised read pointer,
// and produces registered fill level, full, almost-full and a sticky overflow flag.
module write_ptr_ctrl #(
   parameter int unsigned ADDRSIZE  = 9,
   parameter int unsigned AF_THRESH = 2**ADDRSIZE - 4
) (
   input  logic                wclk,
   input  logic                w_rst,
   input  logic                winc,
   input  logic [ADDRSIZE:0]   rptr_sync,
   input  logic                ovf_clr,
   output logic                wen,
   output logic [ADDRSIZE-1:0] waddr,
   output logic [ADDRSIZE:0]   wptr,
   output logic                wfull,
   output logic                walmost_full,
   output logic [ADDRSIZE:0]   wlevel,
   output logic                wovf
);

   localparam logic [ADDRSIZE:0] AF_LVL = (ADDRSIZE+1)'(AF_THRESH);

   logic [ADDRSIZE:0] wbin;
   logic [ADDRSIZE:0] wbin_next;
   logic [ADDRSIZE:0] wgray_next;
   logic [ADDRSIZE:0] rbin_sync;
   logic [ADDRSIZE:0] lvl_next;
   logic [ADDRSIZE:0] full_ptr;
   logic              push;
   logic              full_next;
   logic              af_next;

   // Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      rbin_sync = '0;
      for (int i = 0; i <= int'(ADDRSIZE); i++) begin
         rbin_sync[i] = ^(rptr_sync >> i);
      end
   end

   // Next pointer, level and flag values; a push is refused while full.
   always_comb begin
      push       = winc & ~wfull;
      wbin_next  = wbin + {{ADDRSIZE{1'b0}}, push};
      wgray_next = (wbin_next >> 1) ^ wbin_next;
      lvl_next   = wbin_next - rbin_sync;
      // Full when the write pointer has lapped the read pointer by exactly one pass.
      full_ptr   = {~rptr_sync[ADDRSIZE:ADDRSIZE-1], rptr_sync[ADDRSIZE-2:0]};
      full_next  = (wgray_next == full_ptr);
      af_next    = (lvl_next >= AF_LVL);
   end

   // RAM write port drive; wen is gated by reset so nothing is written during reset.
   always_comb begin
      wen   = winc & ~wfull & ~w_rst;
      waddr = wbin[ADDRSIZE-1:0];
   end

   // Pointer and status registers; overflow set takes priority over clear.
   always_ff @(posedge wclk) begin
      if (w_rst) begin
         wbin         <= '0;
         wptr         <= '0;
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wlevel       <= '0;
         wovf         <= 1'b0;
      end else begin
         wbin         <= wbin_next;
         wptr         <= wgray_next;
         wfull        <= full_next;
         walmost_full <= af_next;
         wlevel       <= lvl_next;
         if (winc & wfull) begin
            wovf <= 1'b1;
         end else if (ovf_clr) begin
            wovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_write_ptr_ctrl.sv
// Self-checking bench for write_ptr_ctrl with ADDRSIZE=4, AF_THRESH=12.
module tb_write_ptr_ctrl;

   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          wclk;
   logic          w_rst;
   logic          winc;
   logic [AW:0]   rptr_sync;
   logic          ovf_clr;
   logic          wen;
   logic [AW-1:0] waddr;
   logic [AW:0]   wptr;
   logic          wfull;
   logic          walmost_full;
   logic [AW:0]   wlevel;
   logic          wovf;

   int checks = 0;
   int errors = 0;
   bit started = 0;

   write_ptr_ctrl #(
      .ADDRSIZE  (AW),
      .AF_THRESH (12)
   ) dut (
      .wclk         (wclk),
      .w_rst        (w_rst),
      .winc         (winc),
      .rptr_sync    (rptr_sync),
      .ovf_clr      (ovf_clr),
      .wen          (wen),
      .waddr        (waddr),
      .wptr         (wptr),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .wlevel       (wlevel),
      .wovf         (wovf)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   typedef struct {
      logic          rst;
      logic          inc;
      logic          clr;
      logic [AW:0]   rptr;
      logic          e_wen;
      logic [AW-1:0] e_waddr;
      logic [AW:0]   e_wptr;
      logic          e_full;
      logic          e_af;
      logic [AW:0]   e_lvl;
      logic          e_ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [AW:0] gray(input int b);
      logic [AW:0] v;
      v = AW'(0) + (AW+1)'(b);
      return v ^ (v >> 1);
   endfunction

   function automatic vec_t mk(input logic rst, input logic inc, input logic clr,
                               input logic [AW:0] rptr, input logic e_wen,
                               input int e_waddr, input logic [AW:0] e_wptr,
                               input logic e_full, input logic e_af, input int e_lvl,
                               input logic e_ovf);
      vec_t v;
      v.rst = rst; v.inc = inc; v.clr = clr; v.rptr = rptr; v.e_wen = e_wen;
      v.e_waddr = (AW)'(e_waddr); v.e_wptr = e_wptr; v.e_full = e_full; v.e_af = e_af;
      v.e_lvl = (AW+1)'(e_lvl); v.e_ovf = e_ovf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply inputs, check same-cycle wen, then check registered outputs after the edge.
   task automatic apply(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("v%0d", idx);
      w_rst = v.rst; winc = v.inc; ovf_clr = v.clr; rptr_sync = v.rptr;
      #1;
      chk({tag, ".wen"}, 32'(wen), 32'(v.e_wen));
      @(posedge wclk);
      #1;
      chk({tag, ".waddr"}, 32'(waddr), 32'(v.e_waddr));
      chk({tag, ".wptr"}, 32'(wptr), 32'(v.e_wptr));
      chk({tag, ".wfull"}, 32'(wfull), 32'(v.e_full));
      chk({tag, ".walmost_full"}, 32'(walmost_full), 32'(v.e_af));
      chk({tag, ".wlevel"}, 32'(wlevel), 32'(v.e_lvl));
      chk({tag, ".wovf"}, 32'(wovf), 32'(v.e_ovf));
   endtask

   // Invariants watched every cycle outside reset.
   logic [AW:0] prev_wptr;
   logic        prev_rst;
   always @(negedge wclk) begin
      if (started) begin
         if (!w_rst) begin
            chk("inv.full_eq_level", 32'(wfull), 32'(wlevel == (AW+1)'(DEPTH)));
            chk("inv.level_le_depth", 32'(wlevel <= (AW+1)'(DEPTH)), 32'd1);
            if (wfull) chk("inv.full_no_wen", 32'(wen), 32'd0);
         end
         if (!prev_rst) chk("inv.wptr_onebit", 32'($countones(wptr ^ prev_wptr) <= 1), 32'd1);
      end
      prev_wptr = wptr;
      prev_rst  = w_rst;
   end

   int wb;
   int rb;

   initial begin
      w_rst = 1'b1; winc = 1'b1; ovf_clr = 1'b0; rptr_sync = '0;

      // Reset with winc held high.
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // Fill 16 entries with read pointer parked at 0.
      for (int i = 1; i <= DEPTH; i++) begin
         vecs.push_back(mk(0, 1, 0, 0, 1, i % DEPTH, gray(i), i == DEPTH, i >= 12, i, 0));
      end
      // Write while full: refused, overflow set.
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 5'b11000, 1, 1, 16, 1));
      // Clear together with write-while-full: set wins.
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, 5'b11000, 1, 1, 16, 1));
      // Clear alone.
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5'b11000, 1, 1, 16, 0));
      // Drain release: read pointer steps 1..8.
      for (int r = 1; r <= 8; r++) begin
         vecs.push_back(mk(0, 0, 0, gray(r), 0, 0, 5'b11000, 0, (16 - r) >= 12, 16 - r, 0));
      end
      // Simultaneous push and one-entry read advance at level 8.
      vecs.push_back(mk(0, 1, 0, gray(9), 1, 1, gray(17), 0, 0, 8, 0));

      foreach (vecs[k]) begin
         apply(vecs[k], k);
         if (k == 1) started = 1;
      end

      // Drain to level 4, then 40 pushes each paired with a read; wbin rolls past 31.
      wb = 17;
      rb = 9;
      for (int i = 0; i < 4; i++) begin
         rb++;
         w_rst = 0; winc = 0; ovf_clr = 0; rptr_sync = gray(rb % 32);
         @(posedge wclk);
         #1;
         chk("drain.wlevel", 32'(wlevel), 32'(wb - rb));
      end
      for (int i = 0; i < 40; i++) begin
         rb++;
         wb++;
         winc = 1; rptr_sync = gray(rb % 32);
         #1;
         chk("wrap.wen", 32'(wen), 32'd1);
         @(posedge wclk);
         #1;
         chk("wrap.waddr", 32'(waddr), 32'(wb % DEPTH));
         chk("wrap.wptr", 32'(wptr), 32'(gray(wb % 32)));
         chk("wrap.wlevel", 32'(wlevel), 32'd4);
         chk("wrap.wfull", 32'(wfull), 32'd0);
      end

      // Reset mid-operation with winc high.
      apply(mk(1, 1, 0, gray(rb % 32), 0, 0, 0, 0, 0, 0, 0), 999);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Time limit guard.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
